keypad_display_ctrl: RTL and testbench
======================================

// Module: keypad_display_ctrl
// PURPOSE
//  Parametrised keypad front end plus multiplexed display in one clocked block: scans an
//  NUM_ROWS x NUM_COLS matrix, synchronises and debounces press and release, maps each
//  accepted key to a hex digit and shifts it into an NUM_DIGITS-deep history. The
//  history is time-multiplexed onto one shared 7-seg bus. Sits directly under the
//  board top, between keypad pins and display pins.
// PARAMETERS
//  NUM_ROWS      4                      keypad rows (NUM_ROWS*NUM_COLS <= 16)
//  NUM_COLS      4                      keypad columns
//  NUM_DIGITS    2                      display digits / history depth (>= 1)
//  SCAN_DIV      48000                  clk cycles per column step while scanning
//  DEBOUNCE_CYC  960000                 stable cycles to accept a press or release (20 ms @ 48 MHz)
//  REFRESH_DIV   24000                  clk cycles each digit is lit
//  KEYMAP        64'hDF0E_C987_B654_A321 nibble i = hex value of key index i
// PORTS
//  clk         in   1                     system clock (48 MHz HSOSC)
//  reset       in   1                     asynchronous, active-low reset
//  row_keys    in   NUM_ROWS              raw rows, active-low (pulled up), unsynchronised
//  col_keys    out  NUM_COLS              column drive, active-low one-hot
//  key_valid   out  1                     1-cycle pulse per accepted press
//  key_code    out  4                     hex value of the last accepted key
//  digits      out  4*NUM_DIGITS          history; [3:0] is the newest digit
//  control     out  NUM_DIGITS            digit enables, active-low one-hot
//  seg         out  7                     segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (reset=0, async): col_keys=~1 (col 0 driven), key_valid=0, key_code=0, digits=0,
//   control=~1, seg=7'b1000000 ("0"), FSM=SCAN, all counters 0.
//  Sync: row_keys passes two flops; all decisions use the synchronised value rows_s.
//  Key index = row*NUM_COLS+col. Value = KEYMAP[4*idx+3 -: 4].
//  FSM:
//   SCAN     : col advances (wraps NUM_COLS-1 -> 0) every SCAN_DIV cycles. If any rows_s bit
//              is 0, latch col and lowest-index low row, clear counter -> DEBOUNCE. Col frozen.
//   DEBOUNCE : latched row low -> count. Count reaches DEBOUNCE_CYC-1 -> next cycle key_valid=1,
//              key_code=value, digits shift (d[i]<=d[i-1], d[0]<=value) -> HELD.
//              Latched row high at any point -> SCAN, no event, col resumes.
//   HELD     : col frozen; latched row high -> clear counter -> RELEASE.
//   RELEASE  : latched row high for DEBOUNCE_CYC cycles -> SCAN. Row low again -> HELD, no event.
//  Exactly one key_valid per press, however long it is held. Other keys are ignored in
//   DEBOUNCE/HELD/RELEASE. Two keys in one column: the lower row index wins.
//  The history drops its oldest digit on overflow. NUM_DIGITS=1: digits just holds the last key.
//  Display: the refresh counter wraps at REFRESH_DIV-1. On wrap, sel advances 0..NUM_DIGITS-1
//   and wraps. control=~(1<<sel). seg=decode(d[sel]), registered in the same cycle as control.
//   Standard hex glyphs 0-F.
//  Display and keypad logic are independent; a digits update shows on the next lit slot.
//  Reset mid-operation: the asynchronous clear applies immediately and no pending key_valid survives.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CYC=8, REFRESH_DIV=4)
//  1 reset low then high, NUM_DIGITS=4 -> col_keys=4'b1110, digits=0, control cycles 1110,
//    1101,1011,0111 every 4 clks, seg=7'b1000000.
//  2 row1 low while col2 driven, 20 clks -> one key_valid, key_code=4'h6, digits[7:0]=8'h06.
//    Then press row0/col0 -> digits[7:0]=8'h61.
//  3 press row2/col1 for 5 clks, then release -> no key_valid, FSM back to SCAN, col resumes.
//  4 hold row3/col1 200 clks -> exactly one key_valid (code 4'h0), col_keys constant.
//    Release with a 3-clk relow glitch -> no second key_valid, SCAN after 8 stable clks.
//  5 rows 0 and 2 low together on col3 -> key_code=4'hA, row2 ignored.
//  6 reset low at debounce count 5 -> outputs at reset values that cycle, no key_valid after
//    reset rises while the key stays held until a fresh 8-clk debounce completes.

Source files
------------

// File: rtl/keypad_display_ctrl_if.sv
// rtl/keypad_display_ctrl_if.sv - pin-side bundle between keypad/display pins and the controller
//
// Purpose : groups the keypad matrix and 7-seg display pins into one bundle.
// Signals : row_keys   raw keypad rows, active-low
//           col_keys   column drive, active-low one-hot
//           key_valid  one-cycle pulse per accepted press
//           key_code   hex value of the last accepted key
//           digits     key history, [3:0] newest
//           control    digit enables, active-low one-hot
//           seg        segments {g,f,e,d,c,b,a}, active-low
// Modports: master = board/pin side, slave = controller side.
interface keypad_display_ctrl_if #(
   parameter int NUM_ROWS   = 4,
   parameter int NUM_COLS   = 4,
   parameter int NUM_DIGITS = 2
);
   logic [NUM_ROWS-1:0]     row_keys;
   logic [NUM_COLS-1:0]     col_keys;
   logic                    key_valid;
   logic [3:0]              key_code;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   control;
   logic [6:0]              seg;

   modport master (
      output row_keys,
      input  col_keys, key_valid, key_code, digits, control, seg
   );

   modport slave (
      input  row_keys,
      output col_keys, key_valid, key_code, digits, control, seg
   );
endinterface

// File: rtl/keypad_display_ctrl.sv
// rtl/keypad_display_ctrl.sv - keypad scanner/debouncer with multiplexed 7-seg history display
//
// Purpose : scans a NUM_ROWS x NUM_COLS keypad, debounces press and release, maps each
//           accepted key through KEYMAP and shifts it into a NUM_DIGITS-deep history that
//           is time-multiplexed onto one shared 7-seg bus.
// Ports   : clk    system clock
//           reset  asynchronous, active-low
//           pins   keypad_display_ctrl_if.slave (row_keys in; col_keys, key_valid,
//                  key_code, digits, control, seg out)
module keypad_display_ctrl #(
   parameter int          NUM_ROWS     = 4,
   parameter int          NUM_COLS     = 4,
   parameter int          NUM_DIGITS   = 2,
   parameter int          SCAN_DIV     = 48000,
   parameter int          DEBOUNCE_CYC = 960000,
   parameter int          REFRESH_DIV  = 24000,
   parameter logic [63:0] KEYMAP       = 64'hDF0E_C987_B654_A321
) (
   input  logic                 clk,
   input  logic                 reset,
   keypad_display_ctrl_if.slave pins
);
   localparam int RW  = (NUM_ROWS > 1)   ? $clog2(NUM_ROWS)   : 1;
   localparam int CW  = (NUM_COLS > 1)   ? $clog2(NUM_COLS)   : 1;
   localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SCW = $clog2(SCAN_DIV + 1);
   localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RFW = $clog2(REFRESH_DIV + 1);
   localparam int DGW = 4 * NUM_DIGITS;

   localparam logic [NUM_COLS-1:0]   ONE_COL   = NUM_COLS'(1);
   localparam logic [NUM_DIGITS-1:0] ONE_DIGIT = NUM_DIGITS'(1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t              state_q, state_d;
   logic [NUM_ROWS-1:0] rows_m_q, rows_m_d;
   logic [NUM_ROWS-1:0] rows_s_q, rows_s_d;
   logic [CW-1:0]       col_q, col_d;
   logic [SCW-1:0]      scan_cnt_q, scan_cnt_d;
   logic [DBW-1:0]      deb_cnt_q, deb_cnt_d;
   logic [RW-1:0]       row_q, row_d;
   logic                key_valid_q, key_valid_d;
   logic [3:0]          key_code_q, key_code_d;
   logic [DGW-1:0]      digits_q, digits_d;
   logic [RFW-1:0]      ref_cnt_q, ref_cnt_d;
   logic [DW-1:0]       sel_q, sel_d;
   logic [NUM_DIGITS-1:0] control_q, control_d;
   logic [6:0]          seg_q, seg_d;

   logic [RW-1:0]       low_row;
   logic                row_low;
   logic [3:0]          key_idx;
   logic [3:0]          key_val;
   logic [DGW+3:0]      shifted;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      case (v)
         4'h0:    hex_to_seg = 7'b1000000;
         4'h1:    hex_to_seg = 7'b1111001;
         4'h2:    hex_to_seg = 7'b0100100;
         4'h3:    hex_to_seg = 7'b0110000;
         4'h4:    hex_to_seg = 7'b0011001;
         4'h5:    hex_to_seg = 7'b0010010;
         4'h6:    hex_to_seg = 7'b0000010;
         4'h7:    hex_to_seg = 7'b1111000;
         4'h8:    hex_to_seg = 7'b0000000;
         4'h9:    hex_to_seg = 7'b0010000;
         4'hA:    hex_to_seg = 7'b0001000;
         4'hB:    hex_to_seg = 7'b0000011;
         4'hC:    hex_to_seg = 7'b1000110;
         4'hD:    hex_to_seg = 7'b0100001;
         4'hE:    hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         rows_m_q    <= '1;       // released keypad reads all-high
         rows_s_q    <= '1;
         col_q       <= '0;
         scan_cnt_q  <= '0;
         deb_cnt_q   <= '0;
         row_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         digits_q    <= '0;
         ref_cnt_q   <= '0;
         sel_q       <= '0;
         control_q   <= ~ONE_DIGIT;
         seg_q       <= 7'b1000000;
      end else begin
         state_q     <= state_d;
         rows_m_q    <= rows_m_d;
         rows_s_q    <= rows_s_d;
         col_q       <= col_d;
         scan_cnt_q  <= scan_cnt_d;
         deb_cnt_q   <= deb_cnt_d;
         row_q       <= row_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         digits_q    <= digits_d;
         ref_cnt_q   <= ref_cnt_d;
         sel_q       <= sel_d;
         control_q   <= control_d;
         seg_q       <= seg_d;
      end
   end

   // Keypad: synchroniser, scan/debounce FSM and history shift.
   always_comb begin
      rows_m_d    = pins.row_keys;
      rows_s_d    = rows_m_q;
      state_d     = state_q;
      col_d       = col_q;
      scan_cnt_d  = scan_cnt_q;
      deb_cnt_d   = deb_cnt_q;
      row_d       = row_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      digits_d    = digits_q;

      // Iterate downward so the lowest-index low row is the one left in low_row.
      low_row = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!rows_s_q[r]) low_row = RW'(r);
      end

      // col_q stays frozen outside SCAN, so it doubles as the latched column.
      row_low = ~rows_s_q[row_q];
      key_idx = 4'(int'(row_q) * NUM_COLS + int'(col_q));
      key_val = KEYMAP[{key_idx, 2'b00} +: 4];
      shifted = {digits_q, key_val};

      case (state_q)
         SCAN: begin
            if (rows_s_q != '1) begin
               row_d     = low_row;
               deb_cnt_d = '0;
               state_d   = DEBOUNCE;
            end else if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
               scan_cnt_d = '0;
               col_d      = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (!row_low) begin
               state_d = SCAN;
            end else if (deb_cnt_q == DBW'(DEBOUNCE_CYC - 1)) begin
               key_valid_d = 1'b1;
               key_code_d  = key_val;
               digits_d    = shifted[DGW-1:0];   // oldest digit falls off the top
               state_d     = HELD;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         HELD: begin
            if (!row_low) begin
               deb_cnt_d = '0;
               state_d   = RELEASE;
            end
         end
         default: begin   // RELEASE
            if (row_low) begin
               state_d = HELD;
            end else if (deb_cnt_q == DBW'(DEBOUNCE_CYC - 1)) begin
               state_d = SCAN;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Display: control and seg change together, only at the slot boundary, so a
   // history update appears on the next lit slot.
   always_comb begin
      ref_cnt_d = ref_cnt_q + 1'b1;
      sel_d     = sel_q;
      control_d = control_q;
      seg_d     = seg_q;
      if (ref_cnt_q == RFW'(REFRESH_DIV - 1)) begin
         ref_cnt_d = '0;
         sel_d     = (sel_q == DW'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
         control_d = ~(ONE_DIGIT << sel_d);
         seg_d     = hex_to_seg(digits_q[{sel_d, 2'b00} +: 4]);
      end
   end

   assign pins.col_keys  = ~(ONE_COL << col_q);
   assign pins.key_valid = key_valid_q;
   assign pins.key_code  = key_code_q;
   assign pins.digits    = digits_q;
   assign pins.control   = control_q;
   assign pins.seg       = seg_q;
endmodule

// File: tb/tb_keypad_display_ctrl.sv
// tb/tb_keypad_display_ctrl.sv - self-checking bench for keypad_display_ctrl
module tb_keypad_display_ctrl;
   localparam int NR = 4;
   localparam int NC = 4;
   localparam int ND = 4;
   localparam int SD = 4;
   localparam int DB = 8;
   localparam int RD = 4;

   localparam int PH_SCAN = 0;
   localparam int PH_QUAL = 1;
   localparam int PH_DOWN = 2;
   localparam int PH_REL  = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic rst_next = 1'b0;

   keypad_display_ctrl_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .NUM_DIGITS(ND)) bus ();

   keypad_display_ctrl #(
      .NUM_ROWS(NR), .NUM_COLS(NC), .NUM_DIGITS(ND),
      .SCAN_DIV(SD), .DEBOUNCE_CYC(DB), .REFRESH_DIV(RD),
      .KEYMAP(64'hDF0E_C987_B654_A321)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pins  (bus.slave)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int kv_cnt  = 0;

   bit pressed [NR][NC];

   logic [63:0] keymap = 64'hDF0E_C987_B654_A321;
   logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model: state it holds is what the outputs must be after the next edge.
   logic [3:0] seen_a, seen_b;   // rows as seen one and two clocks after the pins
   int m_col, m_scan, m_phase, m_run, m_row, m_code, m_ref, m_sel;
   bit m_kv;
   int hist[$];                  // newest first
   logic [3:0] m_ctrl;
   logic [6:0] m_seg;

   task automatic m_reset();
      seen_a = 4'hF; seen_b = 4'hF;
      m_col = 0; m_scan = 0; m_phase = PH_SCAN; m_run = 0; m_row = 0;
      m_kv = 0; m_code = 0; m_ref = 0; m_sel = 0;
      hist = {};
      repeat (ND) hist.push_back(0);
      m_ctrl = 4'b1110;
      m_seg  = glyph[0];
   endtask

   task automatic m_step(input logic [3:0] rk);
      bit down;
      bit found;
      int idx;
      m_ref++;
      if (m_ref == RD) begin
         m_ref  = 0;
         m_sel  = (m_sel + 1) % ND;
         m_ctrl = ~(4'b0001 << m_sel);
         m_seg  = glyph[hist[m_sel]];
      end
      m_kv = 0;
      down = (seen_b[m_row] == 1'b0);
      case (m_phase)
         PH_SCAN: begin
            if (seen_b != 4'hF) begin
               found = 0;
               for (int r = 0; r < NR; r++) begin
                  if (!found && !seen_b[r]) begin m_row = r; found = 1; end
               end
               m_run = 0;
               m_phase = PH_QUAL;
            end else begin
               m_scan++;
               if (m_scan == SD) begin m_scan = 0; m_col = (m_col + 1) % NC; end
            end
         end
         PH_QUAL: begin
            if (!down) m_phase = PH_SCAN;
            else begin
               m_run++;
               if (m_run == DB) begin
                  idx = m_row * NC + m_col;
                  m_code = int'((keymap >> (4 * idx)) & 64'hF);
                  hist.push_front(m_code);
                  void'(hist.pop_back());
                  m_kv = 1;
                  m_phase = PH_DOWN;
               end
            end
         end
         PH_DOWN: begin
            if (!down) begin m_run = 0; m_phase = PH_REL; end
         end
         default: begin
            if (down) m_phase = PH_DOWN;
            else begin
               m_run++;
               if (m_run == DB) m_phase = PH_SCAN;
            end
         end
      endcase
      seen_b = seen_a;
      seen_a = rk;
   endtask

   function automatic logic [3:0] exp_col();
      return ~(4'b0001 << m_col);
   endfunction

   function automatic logic [15:0] exp_digits();
      logic [15:0] e;
      e = '0;
      for (int i = 0; i < ND; i++) e[4*i +: 4] = 4'(hist[i]);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      check("col_keys",  32'(bus.col_keys),  32'(exp_col()));
      check("key_valid", 32'(bus.key_valid), 32'(m_kv));
      check("key_code",  32'(bus.key_code),  32'(m_code));
      check("digits",    32'(bus.digits),    32'(exp_digits()));
      check("control",   32'(bus.control),   32'(m_ctrl));
      check("seg",       32'(bus.seg),       32'(m_seg));
      if (bus.key_valid === 1'b1) kv_cnt++;
   end

   task automatic drive_rows();
      logic [3:0] rk;
      rk = 4'hF;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (pressed[r][c] && bus.col_keys[c] == 1'b0) rk[r] = 1'b0;
      bus.row_keys = rk;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
      reset = rst_next;
      #1;
      drive_rows();
      if (reset) m_step(bus.row_keys);
      else m_reset();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic release_all();
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) pressed[r][c] = 0;
   endtask

   // Literal pin: both the DUT and the model must equal the hand-computed value.
   task automatic pin(input string name, input logic [31:0] dut_v, input logic [31:0] mod_v,
                      input logic [31:0] exp);
      check({name, "_dut"},   dut_v, exp);
      check({name, "_model"}, mod_v, exp);
   endtask

   initial begin
      int kv0;
      bit found;
      int r1, c1, r2, c2;
      m_reset();
      release_all();
      bus.row_keys = 4'hF;

      // 1: reset state and display rotation
      run(3);
      rst_next = 1'b1;
      tick();
      pin("rst_col",     32'(bus.col_keys), 32'(exp_col()),    32'h0E);
      pin("rst_digits",  32'(bus.digits),   32'(exp_digits()), 32'h0);
      pin("rst_control", 32'(bus.control),  32'(m_ctrl),       32'h0E);
      pin("rst_seg",     32'(bus.seg),      32'(m_seg),        32'h40);
      check("rst_key_valid", 32'(bus.key_valid), 32'h0);
      run(4); check("ctrl_slot1", 32'(bus.control), 32'h0D);
      run(4); check("ctrl_slot2", 32'(bus.control), 32'h0B);
      run(4); check("ctrl_slot3", 32'(bus.control), 32'h07);
      run(4); check("ctrl_slot0", 32'(bus.control), 32'h0E);

      // 2: row1/col2 then row0/col0
      kv0 = kv_cnt;
      pressed[1][2] = 1; run(40);
      check("t2_kv_count", 32'(kv_cnt - kv0), 32'd1);
      pin("t2_code",   32'(bus.key_code),     32'(m_code),            32'h6);
      pin("t2_digits", 32'(bus.digits[7:0]),  32'(exp_digits()) & 32'hFF, 32'h06);
      release_all(); run(20);
      pressed[0][0] = 1; run(40);
      release_all(); run(20);
      pin("t2_digits2", 32'(bus.digits[7:0]), 32'(exp_digits()) & 32'hFF, 32'h61);

      // 3: too-short press
      kv0 = kv_cnt;
      pressed[2][1] = 1; run(5);
      release_all(); run(30);
      check("t3_no_event", 32'(kv_cnt - kv0), 32'd0);

      // 4: long hold, then release with a short re-low glitch
      kv0 = kv_cnt;
      pressed[3][1] = 1; run(200);
      check("t4_kv_count", 32'(kv_cnt - kv0), 32'd1);
      pin("t4_code", 32'(bus.key_code), 32'(m_code), 32'h0);
      check("t4_col_frozen", 32'(bus.col_keys), 32'h0D);
      release_all(); run(3);
      pressed[3][1] = 1; run(3);
      release_all(); run(30);
      check("t4_glitch_no_event", 32'(kv_cnt - kv0), 32'd1);

      // 5: two rows in one column, lower row wins
      pressed[0][3] = 1; pressed[2][3] = 1; run(40);
      pin("t5_code", 32'(bus.key_code), 32'(m_code), 32'hA);
      release_all(); run(30);

      // 6: reset in the middle of a debounce
      pressed[0][0] = 1;
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         tick();
         if (m_phase == PH_QUAL && m_run == 5) found = 1;
      end
      if (!found) begin
         n_total++;
         $display("FAIL t6_debounce_wait: count 5 never reached");
      end
      rst_next = 1'b0; tick();
      pin("t6_rst_digits", 32'(bus.digits), 32'(exp_digits()), 32'h0);
      check("t6_rst_kv",   32'(bus.key_valid), 32'h0);
      check("t6_rst_col",  32'(bus.col_keys),  32'h0E);
      rst_next = 1'b1; tick();
      kv0 = kv_cnt;
      run(8);
      check("t6_no_early_event", 32'(kv_cnt - kv0), 32'd0);
      run(40);
      check("t6_fresh_event", 32'(kv_cnt - kv0), 32'd1);
      pin("t6_code", 32'(bus.key_code), 32'(m_code), 32'h1);
      release_all(); run(20);

      // Randomized presses, holds, glitches, double keys and resets
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            rst_next = 1'b0; run($urandom_range(1, 3));
            rst_next = 1'b1;
         end
         r1 = $urandom_range(0, NR - 1); c1 = $urandom_range(0, NC - 1);
         pressed[r1][c1] = 1;
         if ($urandom_range(0, 3) == 0) begin
            r2 = $urandom_range(0, NR - 1); c2 = $urandom_range(0, NC - 1);
            pressed[r2][c2] = 1;
         end
         run($urandom_range(1, 45));
         release_all();
         run($urandom_range(1, 35));
      end
      run(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
